// File: rtl/r4_stage_pingpong_ram_if.sv
// Bus bundle for the radix-4 ping-pong stage RAM.
// The producer stage is the master. The RAM is the slave.
interface r4_stage_pingpong_ram_if #(
  parameter int unsigned DATA_W = 38,
  parameter int unsigned ADDR_W = 8
);
  // Write side. wr_en is an active-low strobe.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic              wr_ready;

  // Read side
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_done;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  // Status
  logic [1:0]        frame_cnt;
  logic              err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
    input  wr_ready, rd_ready, rd_data, rd_valid, frame_cnt, err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
    output wr_ready, rd_ready, rd_data, rd_valid, frame_cnt, err
  );
endinterface

// File: rtl/r4_stage_pingpong_ram.sv
// Double-buffered stage RAM: one bank fills while the other drains.
// Bank ownership moves through commit (wr_done) and release (rd_done) pulses.
module r4_stage_pingpong_ram #(
  parameter int unsigned DATA_W  = 38,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned OUT_REG = 0
) (
  input  logic                   i_clk_sys,
  input  logic                   i_rst_sys_n,
  r4_stage_pingpong_ram_if.slave io_bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [2*Depth];

  logic [1:0]        r_full;
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_err;

  logic              w_wr_ready;
  logic              w_rd_ready;
  logic              w_wr_fire;
  logic              w_commit;
  logic              w_rd_fire;
  logic              w_release;
  logic              w_violation;
  logic [1:0]        w_full_d;

  assign w_wr_ready = ~r_full[r_wr_sel];
  assign w_rd_ready = r_full[r_rd_sel];

  assign w_wr_fire = ~io_bus.wr_en & w_wr_ready;
  assign w_commit  = io_bus.wr_done & w_wr_ready;
  assign w_rd_fire = io_bus.rd_en & w_rd_ready;
  assign w_release = io_bus.rd_done & w_rd_ready;

  // Any strobe or pulse aimed at a bank that is not ours is a protocol error.
  assign w_violation = (~io_bus.wr_en & ~w_wr_ready) |
                       (io_bus.wr_done & ~w_wr_ready) |
                       (io_bus.rd_en & ~w_rd_ready) |
                       (io_bus.rd_done & ~w_rd_ready);

  // Commit needs an empty bank and release needs a full one.
  // So the two events always touch different banks.
  always_comb begin
    w_full_d = r_full;
    if (w_commit) begin
      w_full_d[r_wr_sel] = 1'b1;
    end
    if (w_release) begin
      w_full_d[r_rd_sel] = 1'b0;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_sys_n) begin
    if (!i_rst_sys_n) begin
      r_full   <= 2'b00;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_full <= w_full_d;
      if (w_commit) begin
        r_wr_sel <= ~r_wr_sel;
      end
      if (w_release) begin
        r_rd_sel <= ~r_rd_sel;
      end
      if (w_violation) begin
        r_err <= 1'b1;
      end
    end
  end

  // Storage is not reset. A write during commit still targets the old wr_sel bank.
  always_ff @(posedge i_clk_sys) begin
    if (w_wr_fire) begin
      r_mem[{r_wr_sel, io_bus.wr_addr}] <= io_bus.wr_data;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_sys_n) begin
    if (!i_rst_sys_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_data <= r_mem[{r_rd_sel, io_bus.rd_addr}];
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;

    always_ff @(posedge i_clk_sys or negedge i_rst_sys_n) begin
      if (!i_rst_sys_n) begin
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
      end else begin
        r_out_valid <= r_rd_valid;
        if (r_rd_valid) begin
          r_out_data <= r_rd_data;
        end
      end
    end

    assign io_bus.rd_data  = r_out_data;
    assign io_bus.rd_valid = r_out_valid;
  end else begin : g_no_out_reg
    assign io_bus.rd_data  = r_rd_data;
    assign io_bus.rd_valid = r_rd_valid;
  end

  assign io_bus.wr_ready  = w_wr_ready;
  assign io_bus.rd_ready  = w_rd_ready;
  assign io_bus.frame_cnt = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign io_bus.err       = r_err;

endmodule

// File: tb/tb_r4_stage_pingpong_ram.sv
// Directed bench for r4_stage_pingpong_ram.
// It runs the latency-1 and latency-2 builds side by side on the same stimulus.
module tb_r4_stage_pingpong_ram;

  localparam int unsigned DW = 38;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en, wr_done, rd_en, rd_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;

  r4_stage_pingpong_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
  r4_stage_pingpong_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  assign bus0.wr_en   = wr_en;
  assign bus0.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data;
  assign bus0.wr_done = wr_done;
  assign bus0.rd_en   = rd_en;
  assign bus0.rd_addr = rd_addr;
  assign bus0.rd_done = rd_done;
  assign bus1.wr_en   = wr_en;
  assign bus1.wr_addr = wr_addr;
  assign bus1.wr_data = wr_data;
  assign bus1.wr_done = wr_done;
  assign bus1.rd_en   = rd_en;
  assign bus1.rd_addr = rd_addr;
  assign bus1.rd_done = rd_done;

  r4_stage_pingpong_ram #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0)) dut0 (
    .i_clk_sys   (clk),
    .i_rst_sys_n (rst_n),
    .io_bus      (bus0.slave)
  );

  r4_stage_pingpong_ram #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1)) dut1 (
    .i_clk_sys   (clk),
    .i_rst_sys_n (rst_n),
    .io_bus      (bus1.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_done;
    logic          x_wr_ready;
    logic          x_rd_ready;
    logic [1:0]    x_fc;
    logic          x_valid;
    logic [DW-1:0] x_data;
    logic          x_err;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic we, logic [AW-1:0] wa, logic [DW-1:0] wd, logic wdn,
                              logic re, logic [AW-1:0] ra, logic rdn,
                              logic xw, logic xr, logic [1:0] xfc, logic xv,
                              logic [DW-1:0] xd, logic xe);
    vec_t v;
    v.wr_en = we;  v.wr_addr = wa;  v.wr_data = wd;  v.wr_done = wdn;
    v.rd_en = re;  v.rd_addr = ra;  v.rd_done = rdn;
    v.x_wr_ready = xw;  v.x_rd_ready = xr;  v.x_fc = xfc;
    v.x_valid = xv;  v.x_data = xd;  v.x_err = xe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b1; wr_addr = '0; wr_data = '0; wr_done = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic chk_state(input string t, input logic wr, input logic rd,
                           input logic [1:0] fc, input logic e);
    chk({t, ".wr_ready0"},  64'(bus0.wr_ready),  64'(wr));
    chk({t, ".rd_ready0"},  64'(bus0.rd_ready),  64'(rd));
    chk({t, ".frame_cnt0"}, 64'(bus0.frame_cnt), 64'(fc));
    chk({t, ".err0"},       64'(bus0.err),       64'(e));
    chk({t, ".wr_ready1"},  64'(bus1.wr_ready),  64'(wr));
    chk({t, ".rd_ready1"},  64'(bus1.rd_ready),  64'(rd));
    chk({t, ".frame_cnt1"}, 64'(bus1.frame_cnt), 64'(fc));
    chk({t, ".err1"},       64'(bus1.err),       64'(e));
  endtask

  task automatic chk_rd0(input string t, input logic v, input logic [DW-1:0] d);
    chk({t, ".rd_valid0"}, 64'(bus0.rd_valid), 64'(v));
    chk({t, ".rd_data0"},  64'(bus0.rd_data),  64'(d));
  endtask

  task automatic chk_rd1(input string t, input logic v, input logic [DW-1:0] d);
    chk({t, ".rd_valid1"}, 64'(bus1.rd_valid), 64'(v));
    chk({t, ".rd_data1"},  64'(bus1.rd_data),  64'(d));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          prev_v;
    logic [DW-1:0] prev_d;

    // Short frames. This covers commit, overlapped read/write, release, a simultaneous
    // commit+release, wrap back to bank 0, and finally an illegal empty read.
    vecs[0]  = mk(0, 5, 'h55,   0,  0, 0, 0,  1, 0, 0,  0, 'h0,    0);
    vecs[1]  = mk(0, 6, 'h66,   1,  0, 0, 0,  1, 1, 1,  0, 'h0,    0);
    vecs[2]  = mk(0, 5, 'h1005, 0,  1, 5, 0,  1, 1, 1,  1, 'h55,   0);
    vecs[3]  = mk(1, 0, 'h0,    1,  1, 6, 0,  0, 1, 2,  1, 'h66,   0);
    vecs[4]  = mk(1, 0, 'h0,    0,  1, 5, 1,  1, 1, 1,  1, 'h55,   0);
    vecs[5]  = mk(1, 0, 'h0,    0,  1, 5, 0,  1, 1, 1,  1, 'h1005, 0);
    vecs[6]  = mk(1, 0, 'h0,    0,  0, 0, 0,  1, 1, 1,  0, 'h1005, 0);
    vecs[7]  = mk(0, 7, 'h77,   1,  0, 0, 1,  1, 1, 1,  0, 'h1005, 0);
    vecs[8]  = mk(1, 0, 'h0,    0,  1, 7, 0,  1, 1, 1,  1, 'h77,   0);
    vecs[9]  = mk(1, 0, 'h0,    0,  1, 5, 0,  1, 1, 1,  1, 'h55,   0);
    vecs[10] = mk(1, 0, 'h0,    0,  0, 0, 1,  1, 0, 0,  0, 'h55,   0);
    vecs[11] = mk(1, 0, 'h0,    0,  1, 3, 0,  1, 0, 0,  0, 'h55,   1);

    do_reset();
    chk_state("reset", 1, 0, 0, 0);
    chk_rd0("reset", 0, 0);
    chk_rd1("reset", 0, 0);

    // The latency-2 build shows the latency-1 expectation of the previous step.
    prev_v = 1'b0;
    prev_d = '0;
    for (int i = 0; i < 12; i++) begin
      wr_en = vecs[i].wr_en;  wr_addr = vecs[i].wr_addr;  wr_data = vecs[i].wr_data;
      wr_done = vecs[i].wr_done;  rd_en = vecs[i].rd_en;  rd_addr = vecs[i].rd_addr;
      rd_done = vecs[i].rd_done;
      tick();
      chk_state($sformatf("vec%0d", i), vecs[i].x_wr_ready, vecs[i].x_rd_ready,
                vecs[i].x_fc, vecs[i].x_err);
      chk_rd0($sformatf("vec%0d", i), vecs[i].x_valid, vecs[i].x_data);
      chk_rd1($sformatf("vec%0d", i), prev_v, prev_d);
      prev_v = vecs[i].x_valid;
      prev_d = vecs[i].x_data;
    end
    idle();

    // Full 256-word frame with data = addr. The commit comes with the last write.
    do_reset();
    for (int a = 0; a < 256; a++) begin
      wr_en = 1'b0; wr_addr = a[AW-1:0]; wr_data = DW'(a); wr_done = (a == 255);
      tick();
    end
    idle();
    chk_state("frame0", 1, 1, 1, 0);
    rd_en = 1'b1; rd_addr = 5;
    tick();
    idle();
    chk_rd0("lat_a", 1, 5);
    chk_rd1("lat_a", 0, 0);
    tick();
    chk_rd0("lat_b", 0, 5);
    chk_rd1("lat_b", 1, 5);

    // Drain bank 0 while filling bank 1 with addr+1000.
    for (int a = 0; a < 256; a++) begin
      wr_en = 1'b0; wr_addr = a[AW-1:0]; wr_data = DW'(a + 1000); wr_done = (a == 255);
      rd_en = 1'b1; rd_addr = a[AW-1:0];
      tick();
      chk_rd0($sformatf("ovl%0d", a), 1, DW'(a));
    end
    idle();
    chk_state("ovl_full", 0, 1, 2, 0);
    rd_done = 1'b1;
    tick();
    idle();
    chk_state("ovl_rel", 1, 1, 1, 0);
    rd_en = 1'b1; rd_addr = 5;
    tick();
    idle();
    chk_rd0("bank1", 1, 1005);
    tick();
    chk_rd1("bank1", 1, 1005);

    // Fill bank 0 with addr+2000. Both banks are then full, and an extra write must be dropped.
    for (int a = 0; a < 256; a++) begin
      wr_en = 1'b0; wr_addr = a[AW-1:0]; wr_data = DW'(a + 2000); wr_done = (a == 255);
      tick();
    end
    idle();
    chk_state("full2", 0, 1, 2, 0);
    wr_en = 1'b0; wr_addr = 5; wr_data = 'h3BAD;
    tick();
    idle();
    chk_state("full_wr", 0, 1, 2, 1);
    rd_done = 1'b1;
    tick();
    idle();
    chk_state("full_rel", 1, 1, 1, 1);
    rd_en = 1'b1; rd_addr = 5;
    tick();
    idle();
    chk_rd0("no_clobber", 1, 2005);
    tick();
    chk_rd1("no_clobber", 1, 2005);

    // Apply reset asynchronously, between clock edges, in the middle of a write.
    wr_en = 1'b0; wr_addr = 9; wr_data = 'h99;
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 1, 0, 0, 0);
    chk_rd0("async_rst", 0, 0);
    chk_rd1("async_rst", 0, 0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();

    // Illegal read and release on an empty RAM, each from a fresh reset.
    rd_en = 1'b1; rd_addr = 3;
    tick();
    idle();
    chk_state("empty_rd", 1, 0, 0, 1);
    chk_rd0("empty_rd", 0, 0);
    do_reset();
    rd_done = 1'b1;
    tick();
    idle();
    chk_state("empty_rel", 1, 0, 0, 1);

    // Six tagged frames. Each middle cycle commits one frame and releases another.
    do_reset();
    wr_en = 1'b0; wr_addr = 0; wr_data = 0; wr_done = 1'b1;
    tick();
    for (int k = 1; k < 6; k++) begin
      wr_en = 1'b0; wr_addr = 0; wr_data = DW'(k); wr_done = 1'b1;
      rd_en = 1'b1; rd_addr = 0; rd_done = 1'b1;
      tick();
      idle();
      chk_rd0($sformatf("wrap%0d", k), 1, DW'(k - 1));
      chk_state($sformatf("wrap%0d", k), 1, 1, 1, 0);
      if (k >= 2) chk_rd1($sformatf("wrap%0d", k), 1, DW'(k - 2));
    end
    rd_en = 1'b1; rd_addr = 0; rd_done = 1'b1;
    tick();
    idle();
    chk_rd0("wrap_end", 1, 5);
    chk_rd1("wrap_end", 1, 4);
    chk_state("wrap_end", 1, 0, 0, 0);
    tick();
    chk_rd1("wrap_last", 1, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
